// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache definitions used by the memory-port arbiter and its picker.
//   word         : byte address
//   line         : one cache line of data (16 bytes)
//   line_be      : per-byte enables for one line
//   mem_port_idx : index of a requester on the shared memory port (up to 8)
//   arb_state_e  : arbiter FSM states
//   rr_distance  : circular distance used for round-robin priority
package cache_mem_arbiter_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned MAX_PORTS  = 8;

  typedef logic [ADDR_W-1:0]              word;
  typedef logic [LINE_W-1:0]              line;
  typedef logic [LINE_BYTES-1:0]          line_be;
  typedef logic [$clog2(MAX_PORTS)-1:0]   mem_port_idx;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // Number of steps after `last` (mod ports) at which `idx` is reached;
  // the port right after `last` has distance 0. Requires last < ports.
  function automatic int unsigned rr_distance(input mem_port_idx idx,
                                              input mem_port_idx last,
                                              input int unsigned ports);
    return (32'(idx) + ports - 1 - 32'(last)) % ports;
  endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational circular priority select.
//   req      : request vector, one bit per port
//   last     : index of the most recently served port
//   pick     : one-hot winner (all zero when nothing requests)
//   pick_idx : index of the winner (zero when nothing requests)
// The first requesting port in circular order starting at last+1 wins.
module cache_rr_pick
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned PORTS = 4
) (
  input  logic [PORTS-1:0] req,
  input  mem_port_idx      last,
  output logic [PORTS-1:0] pick,
  output mem_port_idx      pick_idx
);

  always_comb begin
    int unsigned best;
    pick     = '0;
    pick_idx = '0;
    best     = PORTS;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (req[i] && (rr_distance(mem_port_idx'(i), last, PORTS) < best)) begin
        best        = rr_distance(mem_port_idx'(i), last, PORTS);
        pick        = '0;
        pick[i]     = 1'b1;
        pick_idx    = mem_port_idx'(i);
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide Avalon-MM memory port among
// PORTS cache controllers. One transaction per grant, one bubble cycle
// between grants.
//   clk, rst           : clock, synchronous active-high reset
//   in_address/read/write/writedata/byteenable : per-port master requests
//   in_waitrequest     : per-port stall (high unless granted and memory ready)
//   in_readdata        : broadcast of mem_readdata
//   mem_*              : forwarded command of the granted port
//   mem_waitrequest    : memory stall
//   mem_readdata       : memory read line
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned PORTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  word               in_address     [PORTS],
  input  logic [PORTS-1:0]  in_read,
  input  logic [PORTS-1:0]  in_write,
  input  line               in_writedata   [PORTS],
  input  line_be            in_byteenable  [PORTS],
  output logic [PORTS-1:0]  in_waitrequest,
  output line               in_readdata,
  output word               mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output line               mem_writedata,
  output line_be            mem_byteenable,
  input  logic              mem_waitrequest,
  input  line               mem_readdata
);

  arb_state_e        state_q, state_d;
  logic [PORTS-1:0]  grant_q, grant_d;
  mem_port_idx       gidx_q,  gidx_d;
  mem_port_idx       last_q,  last_d;

  logic [PORTS-1:0]  req;
  logic [PORTS-1:0]  pick;
  mem_port_idx       pick_idx;

  assign req = in_read | in_write;

  cache_rr_pick #(
    .PORTS (PORTS)
  ) u_pick (
    .req      (req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Forwarding is an AND-OR over the one-hot grant, so every mem_* output
  // is zero whenever nothing is granted (IDLE).
  always_comb begin
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        mem_address    = mem_address    | in_address[i];
        mem_read       = mem_read       | in_read[i];
        mem_write      = mem_write      | in_write[i];
        mem_writedata  = mem_writedata  | in_writedata[i];
        mem_byteenable = mem_byteenable | in_byteenable[i];
      end
    end
  end

  assign in_waitrequest = ~grant_q | {PORTS{mem_waitrequest}};
  assign in_readdata    = mem_readdata;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!(mem_read || mem_write)) begin
          // Granted port abandoned its command: release without moving
          // the round-robin pointer.
          grant_d = '0;
          state_d = ARB_IDLE;
        end else if (!mem_waitrequest) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= mem_port_idx'(PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

endmodule
